// File: rtl/pll_phase_stepper.sv
// Fine-phase stepper for the ECP5 EHXPLLL dynamic phase port.
// Tracks per-channel phase and emits PHASESEL/PHASEDIR/PHASESTEP pulse trains.
module pll_phase_stepper #(
  parameter int NCHAN         = 3,
  parameter int STEPS_PER_REV = 32,
  parameter int POS_W         = $clog2(STEPS_PER_REV),
  parameter int INIT_POS      = 1,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 2,
  parameter int GAP_CYC       = 4
) (
  input  logic                   clki,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_chan,
  input  logic                   req_abs,
  input  logic [POS_W-1:0]       req_val,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [NCHAN*POS_W-1:0] pos_o,
  output logic [1:0]             phasesel,
  output logic                   phasedir,
  output logic                   phasestep
);

  typedef enum logic [2:0] {
    IDLE, CALC, SETUP, PULSE, GAP, DONE
  } state_t;

  localparam int TW = 8;
  localparam logic [POS_W-1:0] HALF =
    POS_W'(STEPS_PER_REV / 2);

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [POS_W-1:0] cnt;
  logic [1:0]       chan;
  logic             abs_q;
  logic [POS_W-1:0] val;
  logic [POS_W-1:0] pos [NCHAN];

  logic             chan_ok;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] diff;
  logic [POS_W-1:0] c_cnt;
  logic             c_dir;

  assign req_ready = (state == IDLE) && pll_locked && !rst;
  assign chan_ok   = 32'(chan) < 32'(NCHAN);

  for (genvar g = 0; g < NCHAN; g++) begin : g_pos
    assign pos_o[g*POS_W +: POS_W] = pos[g];
  end

  // Shortest-path direction and step count for the captured request
  always_comb begin
    cur   = '0;
    for (int i = 0; i < NCHAN; i++)
      if (2'(i) == chan) cur = pos[i];
    diff  = val - cur;
    c_dir = 1'b0;
    c_cnt = '0;
    if (!abs_q) begin
      c_dir = val[POS_W-1];
      c_cnt = c_dir ? -val : val;
    end else if (diff > HALF) begin
      c_dir = 1'b1;
      c_cnt = -diff;
    end else begin
      c_cnt = diff;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      cnt       <= '0;
      chan      <= '0;
      abs_q     <= 1'b0;
      val       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b1;
      for (int i = 0; i < NCHAN; i++)
        pos[i] <= POS_W'(INIT_POS);
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            chan  <= req_chan;
            abs_q <= req_abs;
            val   <= req_val;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (!chan_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            phasesel <= chan;
            phasedir <= c_dir;
            cnt      <= c_cnt;
            if (c_cnt == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              tmr   <= TW'(SETUP_CYC - 1);
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            phasestep <= 1'b0;
            tmr       <= TW'(PULSE_CYC - 1);
            state     <= PULSE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            for (int i = 0; i < NCHAN; i++)
              if (2'(i) == chan)
                pos[i] <= phasedir ? pos[i] - 1'b1
                                   : pos[i] + 1'b1;
            cnt       <= cnt - 1'b1;
            phasestep <= 1'b1;
            tmr       <= TW'(GAP_CYC - 1);
            state     <= GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GAP: begin
          // Hold at gap end while unlocked; resume once lock returns
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (pll_locked) begin
            if (cnt != '0) begin
              phasestep <= 1'b0;
              tmr       <= TW'(PULSE_CYC - 1);
              state     <= PULSE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Bench for pll_phase_stepper: directed scenarios plus random requests
// scored against a step-schedule model of the phase port.
module tb_pll_phase_stepper;
  localparam int R  = 32;
  localparam int PW = 5;
  localparam int NC = 3;

  logic clki = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_chan = '0;
  logic req_abs = 1'b0;
  logic [PW-1:0] req_val = '0;
  logic busy, done, err;
  logic [NC*PW-1:0] pos_o;
  logic [1:0] phasesel;
  logic phasedir, phasestep;

  int checks = 0;
  int failures = 0;

  always #5 clki = ~clki;

  pll_phase_stepper dut (
    .clki(clki), .rst(rst), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_abs(req_abs), .req_val(req_val),
    .busy(busy), .done(done), .err(err), .pos_o(pos_o),
    .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep)
  );

  int mpos[NC];
  int obs_lows[$];
  int exp_lows[$];
  int done_r;
  bit err_seen, timeout, ready_in_drop;
  logic [1:0] sel_seen;
  logic dir_seen;
  int mk, med;
  bit mdir, mbad;

  function automatic logic [NC*PW-1:0] exp_pos();
    logic [NC*PW-1:0] e;
    e = '0;
    for (int i = 0; i < NC; i++) e[i*PW +: PW] = PW'(mpos[i]);
    return e;
  endfunction

  function automatic bit lows_match();
    if (obs_lows.size() != exp_lows.size()) return 1'b0;
    for (int i = 0; i < obs_lows.size(); i++)
      if (obs_lows[i] != exp_lows[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    pll_locked = 1'b1;
    repeat (2) @(posedge clki);
    #1 rst = 1'b0;
    for (int i = 0; i < NC; i++) mpos[i] = 1;
  endtask

  // Expected schedule, offsets relative to the accept cycle N
  task automatic model_plan(input int ch, input bit ab, input int v,
                            input int ds, input int dl);
    int s, d, t, g;
    exp_lows.delete();
    mk = 0; mdir = 0; med = 2;
    mbad = (ch >= NC);
    if (mbad) return;
    if (!ab) begin
      s = (v >= R/2) ? v - R : v;
      mdir = (s < 0);
      mk = mdir ? -s : s;
    end else begin
      d = ((v - mpos[ch]) % R + R) % R;
      mdir = (d > R/2);
      mk = (d == 0) ? 0 : (mdir ? R - d : d);
    end
    t = 4;
    for (int i = 0; i < mk; i++) begin
      exp_lows.push_back(t);
      exp_lows.push_back(t + 1);
      g = t + 5;
      while (dl > 0 && g >= ds && g < ds + dl) g++;
      t = g + 1;
    end
    if (mk > 0) med = t;
    mpos[ch] = (mpos[ch] + (mdir ? R - mk : mk)) % R;
  endtask

  task automatic do_req(input int ch, input bit ab, input int v,
                        input int ds, input int dl);
    int n_wait;
    n_wait = 0;
    obs_lows.delete();
    done_r = -1; err_seen = 0; timeout = 0; ready_in_drop = 0;
    sel_seen = '0; dir_seen = 1'b0;
    @(posedge clki); #1;
    while (!req_ready && n_wait < 50) begin
      @(posedge clki); #1;
      n_wait++;
    end
    if (!req_ready) begin
      timeout = 1;
      return;
    end
    req_valid = 1'b1;
    req_chan = 2'(ch);
    req_abs = ab;
    req_val = PW'(v);
    for (int r = 1; r <= 400; r++) begin
      @(posedge clki); #1;
      req_valid = 1'b0;
      pll_locked = !(dl > 0 && r >= ds && r < ds + dl);
      @(negedge clki);
      if (!phasestep) begin
        if (obs_lows.size() == 0) begin
          sel_seen = phasesel;
          dir_seen = phasedir;
        end
        obs_lows.push_back(r);
      end
      if (!pll_locked && req_ready) ready_in_drop = 1;
      if (done) begin
        done_r = r;
        err_seen = err;
        break;
      end
    end
    pll_locked = 1'b1;
    if (done_r < 0) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clki);
    @(negedge clki);
    checks++;
    if (req_ready !== 1'b0 || phasestep !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold: ready=%b step=%b expected 0/1",
               req_ready, phasestep);
    end
    do_reset();
    @(negedge clki);
    checks++;
    if (phasestep !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0) begin
      failures++;
      $display("FAIL rst_outs: step=%b busy=%b done=%b err=%b",
               phasestep, busy, done, err);
    end
    checks++;
    if (pos_o !== exp_pos()) begin
      failures++;
      $display("FAIL rst_pos: got %h expected %h", pos_o, exp_pos());
    end
    checks++;
    if (req_ready !== 1'b1 || {phasesel, phasedir} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ready: ready=%b sel=%0d dir=%b",
               req_ready, phasesel, phasedir);
    end
  endtask

  task automatic test_rel_basic();
    do_reset();
    model_plan(1, 0, 3, 0, 0);
    do_req(1, 0, 3, 0, 0);
    checks++;
    if (timeout || done_r !== 22 || done_r !== med) begin
      failures++;
      $display("FAIL rel3_done: got %0d expected 22", done_r);
    end
    checks++;
    if (!lows_match() || obs_lows[0] !== 4) begin
      failures++;
      $display("FAIL rel3_lows: got %0d lows expected %0d",
               obs_lows.size(), exp_lows.size());
    end
    checks++;
    if ({sel_seen, dir_seen, err_seen} !== {2'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rel3_seldir: sel=%0d dir=%b err=%b",
               sel_seen, dir_seen, err_seen);
    end
    checks++;
    if (pos_o[PW +: PW] !== 5'd4) begin
      failures++;
      $display("FAIL rel3_pos: got %0d expected 4", pos_o[PW +: PW]);
    end
  endtask

  task automatic test_abs();
    do_reset();
    model_plan(0, 1, 30, 0, 0);
    do_req(0, 1, 30, 0, 0);
    checks++;
    if (timeout || done_r !== med || !lows_match() ||
        obs_lows.size() !== 6) begin
      failures++;
      $display("FAIL abs30_sched: done=%0d exp %0d lows=%0d exp 6",
               done_r, med, obs_lows.size());
    end
    checks++;
    if (dir_seen !== 1'b1 || pos_o[PW-1:0] !== 5'd30) begin
      failures++;
      $display("FAIL abs30_pos: dir=%b pos=%0d expected 1/30",
               dir_seen, pos_o[PW-1:0]);
    end
    do_reset();
    model_plan(0, 1, 17, 0, 0);
    do_req(0, 1, 17, 0, 0);
    checks++;
    if (timeout || done_r !== 100 || obs_lows.size() !== 32 ||
        !lows_match()) begin
      failures++;
      $display("FAIL abs17_sched: done=%0d exp 100 lows=%0d exp 32",
               done_r, obs_lows.size());
    end
    checks++;
    if (dir_seen !== 1'b0 || pos_o[PW-1:0] !== 5'd17) begin
      failures++;
      $display("FAIL abs17_pos: dir=%b pos=%0d expected 0/17",
               dir_seen, pos_o[PW-1:0]);
    end
  endtask

  task automatic test_rel_neg();
    do_reset();
    model_plan(2, 0, 16, 0, 0);
    do_req(2, 0, 16, 0, 0);
    checks++;
    if (timeout || done_r !== med || obs_lows.size() !== 32 ||
        dir_seen !== 1'b1 || pos_o !== exp_pos()) begin
      failures++;
      $display("FAIL relm16: done=%0d exp %0d lows=%0d dir=%b pos=%h",
               done_r, med, obs_lows.size(), dir_seen, pos_o);
    end
  endtask

  task automatic test_zero();
    do_reset();
    model_plan(1, 1, 1, 0, 0);
    do_req(1, 1, 1, 0, 0);
    checks++;
    if (timeout || done_r !== 2 || obs_lows.size() !== 0 ||
        err_seen !== 1'b0) begin
      failures++;
      $display("FAIL zero: done=%0d exp 2 lows=%0d err=%b",
               done_r, obs_lows.size(), err_seen);
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    model_plan(2, 0, 4, 13, 10);
    do_req(2, 0, 4, 13, 10);
    checks++;
    if (timeout || done_r !== med || !lows_match()) begin
      failures++;
      $display("FAIL lock_sched: done=%0d exp %0d lows=%0d exp %0d",
               done_r, med, obs_lows.size(), exp_lows.size());
    end
    checks++;
    if (ready_in_drop || pos_o[2*PW +: PW] !== 5'd5) begin
      failures++;
      $display("FAIL lock_pos: ready_in_drop=%b pos=%0d expected 0/5",
               ready_in_drop, pos_o[2*PW +: PW]);
    end
  endtask

  task automatic test_idle_lock();
    bit bad;
    bad = 0;
    @(posedge clki); #1;
    pll_locked = 1'b0;
    req_valid = 1'b1;
    req_chan = 2'd0;
    req_abs = 1'b0;
    req_val = 5'd1;
    repeat (5) begin
      @(negedge clki);
      if (req_ready !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    @(posedge clki); #1;
    req_valid = 1'b0;
    pll_locked = 1'b1;
    checks++;
    if (bad || pos_o !== exp_pos()) begin
      failures++;
      $display("FAIL idle_lock: accepted=%b pos=%h expected %h",
               bad, pos_o, exp_pos());
    end
  endtask

  task automatic test_bad_chan();
    model_plan(3, 0, 5, 0, 0);
    do_req(3, 0, 5, 0, 0);
    checks++;
    if (timeout || done_r !== 2 || err_seen !== 1'b1 ||
        obs_lows.size() !== 0 || pos_o !== exp_pos()) begin
      failures++;
      $display("FAIL bad_chan: done=%0d err=%b lows=%0d pos=%h",
               done_r, err_seen, obs_lows.size(), pos_o);
    end
  endtask

  task automatic test_random();
    int ch, v;
    bit ab;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      ch = $urandom_range(0, 3);
      ab = 1'($urandom_range(0, 1));
      v  = $urandom_range(0, R - 1);
      model_plan(ch, ab, v, 0, 0);
      do_req(ch, ab, v, 0, 0);
      checks++;
      if (timeout || done_r !== med || err_seen !== mbad) begin
        failures++;
        $display("FAIL rnd%0d_done: ch=%0d abs=%b v=%0d done=%0d exp %0d",
                 i, ch, ab, v, done_r, med);
      end
      checks++;
      if (!lows_match() || pos_o !== exp_pos()) begin
        failures++;
        $display("FAIL rnd%0d_pos: lows=%0d exp %0d pos=%h exp %h",
                 i, obs_lows.size(), exp_lows.size(), pos_o, exp_pos());
      end
      if (mk > 0) begin
        checks++;
        if ({sel_seen, dir_seen} !== {2'(ch), mdir}) begin
          failures++;
          $display("FAIL rnd%0d_seldir: sel=%0d dir=%b exp %0d/%b",
                   i, sel_seen, dir_seen, ch, mdir);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 0;
    @(posedge clki); #1;
    req_valid = 1'b1;
    req_chan = 2'd0;
    req_abs = 1'b0;
    req_val = 5'd3;
    for (int r = 0; r < 20; r++) begin
      @(posedge clki); #1;
      req_valid = 1'b0;
      @(negedge clki);
      if (!phasestep) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midrst_pulse: no low pulse seen");
    end
    rst = 1'b1;
    @(negedge clki);
    for (int i = 0; i < NC; i++) mpos[i] = 1;
    checks++;
    if (phasestep !== 1'b1 || busy !== 1'b0 || pos_o !== exp_pos()) begin
      failures++;
      $display("FAIL midrst: step=%b busy=%b pos=%h exp %h",
               phasestep, busy, pos_o, exp_pos());
    end
    @(posedge clki); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rel_basic();
    test_abs();
    test_rel_neg();
    test_zero();
    test_lock_drop();
    test_idle_lock();
    test_bad_chan();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
